// File: rtl/picomips_ctrl.sv
// picoMips fetch/decode sequencer: FETCH -> LOAD -> EXEC, one instruction per three cycles.
// Drives the ALU control bundle from the instruction register and owns the PC.
module picomips_ctrl #(
  parameter int PC_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            Run,
  input  logic            SwReady,
  output logic [PC_W-1:0] ProgAddr,
  input  logic [15:0]     ProgData,
  output logic [7:0]      Imm,
  output logic [2:0]      Func,
  output logic [3:0]      RegAddr,
  output logic            RegWE,
  output logic            WE,
  output logic            SelSW,
  output logic            SelImm,
  output logic            UseMul,
  output logic            UseACC,
  output logic            Waiting
);

  typedef enum logic [1:0] {FETCH, LOAD, EXEC} state_t;

  localparam logic [3:0] OP_LDSW = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_ADDR = 4'h4;
  localparam logic [3:0] OP_MULI = 4'h5;
  localparam logic [3:0] OP_WTH  = 4'h6;
  localparam logic [3:0] OP_WTL  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_STR  = 4'h9;

  state_t                 state_reg;
  logic [PC_W-1:0]        pc_reg;
  logic [15:0]            ir_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   we_reg;
  logic                   sel_sw_reg;
  logic                   sel_imm_reg;
  logic                   use_mul_reg;
  logic                   use_acc_reg;
  logic                   reg_we_reg;
  logic [2:0]             func_reg;
  logic                   waiting_reg;

  logic                   sw_sync;
  logic                   sw_sync_next;
  logic [3:0]             ir_op;

  assign sw_sync      = sync_reg[SYNC_STAGES-1];
  assign sw_sync_next = sync_reg[SYNC_STAGES-2];
  assign ir_op        = ir_reg[15:12];

  // Bundle order: {WE, SelSW, SelImm, UseMul, UseACC, RegWE}
  function automatic logic [5:0] decode(input logic [3:0] op);
    case (op)
      OP_LDSW: decode = 6'b110000;
      OP_LDI:  decode = 6'b101000;
      OP_ADDI: decode = 6'b101010;
      OP_ADDR: decode = 6'b100010;
      OP_MULI: decode = 6'b100110;
      OP_STR:  decode = 6'b000001;
      default: decode = 6'b000000;
    endcase
  endfunction

  function automatic logic blocked(input logic [3:0] op, input logic sw);
    blocked = ((op == OP_WTH) && !sw) || ((op == OP_WTL) && sw);
  endfunction

  // Outputs are registered one edge ahead: the LOAD->EXEC edge decodes ProgData,
  // and Waiting looks at the synchroniser stage that becomes visible next cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg   <= FETCH;
      pc_reg      <= '0;
      ir_reg      <= '0;
      sync_reg    <= '0;
      we_reg      <= 1'b0;
      sel_sw_reg  <= 1'b0;
      sel_imm_reg <= 1'b0;
      use_mul_reg <= 1'b0;
      use_acc_reg <= 1'b0;
      reg_we_reg  <= 1'b0;
      func_reg    <= '0;
      waiting_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], SwReady};
      case (state_reg)
        FETCH: begin
          if (Run) state_reg <= LOAD;
        end
        LOAD: begin
          ir_reg    <= ProgData;
          state_reg <= EXEC;
          {we_reg, sel_sw_reg, sel_imm_reg, use_mul_reg, use_acc_reg, reg_we_reg}
                    <= decode(ProgData[15:12]);
          func_reg    <= ProgData[10:8];
          waiting_reg <= blocked(ProgData[15:12], sw_sync_next);
        end
        EXEC: begin
          if (blocked(ir_op, sw_sync)) begin
            waiting_reg <= blocked(ir_op, sw_sync_next);
          end else begin
            if (ir_op == OP_JMP) pc_reg <= PC_W'(ir_reg[7:0]);
            else                 pc_reg <= pc_reg + PC_W'(1);
            state_reg   <= FETCH;
            we_reg      <= 1'b0;
            sel_sw_reg  <= 1'b0;
            sel_imm_reg <= 1'b0;
            use_mul_reg <= 1'b0;
            use_acc_reg <= 1'b0;
            reg_we_reg  <= 1'b0;
            func_reg    <= '0;
            waiting_reg <= 1'b0;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign ProgAddr = pc_reg;
  assign Imm      = ir_reg[7:0];
  assign RegAddr  = ir_reg[11:8];
  assign Func     = func_reg;
  assign WE       = we_reg;
  assign SelSW    = sel_sw_reg;
  assign SelImm   = sel_imm_reg;
  assign UseMul   = use_mul_reg;
  assign UseACC   = use_acc_reg;
  assign RegWE    = reg_we_reg;
  assign Waiting  = waiting_reg;

endmodule

// File: tb/tb_picomips_ctrl.sv
// Directed bench for picomips_ctrl: opcode decode table, per-cycle pipeline table,
// and hand sequences for reset abort, wait-on-switch, PC wrap/jump and Run gating.
module tb_picomips_ctrl;

  localparam int PC_W = 8;

  logic            Clock = 1'b0;
  logic            nReset = 1'b0;
  logic            Run = 1'b0;
  logic            SwReady = 1'b0;
  logic [PC_W-1:0] ProgAddr;
  logic [15:0]     ProgData;
  logic [7:0]      Imm;
  logic [2:0]      Func;
  logic [3:0]      RegAddr;
  logic            RegWE, WE, SelSW, SelImm, UseMul, UseACC, Waiting;

  logic [15:0] rom [0:255];
  int applied = 0;
  int miscompares = 0;

  picomips_ctrl #(.PC_W(PC_W), .SYNC_STAGES(2)) dut (
    .Clock(Clock), .nReset(nReset), .Run(Run), .SwReady(SwReady),
    .ProgAddr(ProgAddr), .ProgData(ProgData),
    .Imm(Imm), .Func(Func), .RegAddr(RegAddr), .RegWE(RegWE), .WE(WE),
    .SelSW(SelSW), .SelImm(SelImm), .UseMul(UseMul), .UseACC(UseACC),
    .Waiting(Waiting)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read program ROM
  always @(posedge Clock) ProgData <= rom[ProgAddr];

  typedef struct {
    logic [15:0] instr;
    logic        sw;
    logic [5:0]  ctrl;     // {WE, SelSW, SelImm, UseMul, UseACC, RegWE}
    logic [2:0]  func;
    logic [3:0]  raddr;
    logic [7:0]  imm;
    logic [7:0]  next_pc;
  } dec_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [5:0] ctrl;
    logic [2:0] func;
    logic [7:0] imm;
  } cyc_vec_t;

  dec_vec_t dec_tab [16];
  cyc_vec_t cyc_tab [9];

  function automatic logic [5:0] ctrl_now();
    ctrl_now = {WE, SelSW, SelImm, UseMul, UseACC, RegWE};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Leaves the bench at the negedge of the first FETCH cycle after release.
  task automatic restart();
    nReset = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1 nReset = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    logic found;

    dec_tab[0]  = '{16'h0512, 1'b0, 6'b000000, 3'd5, 4'h5, 8'h12, 8'h01};
    dec_tab[1]  = '{16'h1300, 1'b0, 6'b110000, 3'd3, 4'h3, 8'h00, 8'h01};
    dec_tab[2]  = '{16'h2A7F, 1'b0, 6'b101000, 3'd2, 4'hA, 8'h7F, 8'h01};
    dec_tab[3]  = '{16'h3081, 1'b0, 6'b101010, 3'd0, 4'h0, 8'h81, 8'h01};
    dec_tab[4]  = '{16'h4700, 1'b0, 6'b100010, 3'd7, 4'h7, 8'h00, 8'h01};
    dec_tab[5]  = '{16'h5C40, 1'b0, 6'b100110, 3'd4, 4'hC, 8'h40, 8'h01};
    dec_tab[6]  = '{16'h6000, 1'b1, 6'b000000, 3'd0, 4'h0, 8'h00, 8'h01};
    dec_tab[7]  = '{16'h7000, 1'b0, 6'b000000, 3'd0, 4'h0, 8'h00, 8'h01};
    dec_tab[8]  = '{16'h8020, 1'b0, 6'b000000, 3'd0, 4'h0, 8'h20, 8'h20};
    dec_tab[9]  = '{16'h9B00, 1'b0, 6'b000001, 3'd3, 4'hB, 8'h00, 8'h01};
    dec_tab[10] = '{16'hA1FF, 1'b0, 6'b000000, 3'd1, 4'h1, 8'hFF, 8'h01};
    dec_tab[11] = '{16'hB000, 1'b0, 6'b000000, 3'd0, 4'h0, 8'h00, 8'h01};
    dec_tab[12] = '{16'hC000, 1'b0, 6'b000000, 3'd0, 4'h0, 8'h00, 8'h01};
    dec_tab[13] = '{16'hD000, 1'b0, 6'b000000, 3'd0, 4'h0, 8'h00, 8'h01};
    dec_tab[14] = '{16'hE000, 1'b0, 6'b000000, 3'd0, 4'h0, 8'h00, 8'h01};
    dec_tab[15] = '{16'hFFFF, 1'b0, 6'b000000, 3'd7, 4'hF, 8'hFF, 8'h01};

    // LDI 0x10 ; ADDI 0x05 ; MULI 0x40 with non-zero func fields
    cyc_tab[0] = '{8'h00, 6'b000000, 3'd0, 8'h00};
    cyc_tab[1] = '{8'h00, 6'b000000, 3'd0, 8'h00};
    cyc_tab[2] = '{8'h00, 6'b101000, 3'd5, 8'h10};
    cyc_tab[3] = '{8'h01, 6'b000000, 3'd0, 8'h10};
    cyc_tab[4] = '{8'h01, 6'b000000, 3'd0, 8'h10};
    cyc_tab[5] = '{8'h01, 6'b101010, 3'd6, 8'h05};
    cyc_tab[6] = '{8'h02, 6'b000000, 3'd0, 8'h05};
    cyc_tab[7] = '{8'h02, 6'b000000, 3'd0, 8'h05};
    cyc_tab[8] = '{8'h02, 6'b100110, 3'd3, 8'h40};

    clear_rom();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_state", 32'({ProgAddr, ctrl_now(), Func, Imm, RegAddr, Waiting}), 32'd0);

    // Opcode decode, one instruction at address 0 per vector
    Run = 1'b1;
    for (int v = 0; v < 16; v++) begin
      clear_rom();
      rom[0]  = dec_tab[v].instr;
      SwReady = dec_tab[v].sw;
      restart();
      tick();
      tick();
      check($sformatf("decode_%h", dec_tab[v].instr),
            32'({ctrl_now(), Func, RegAddr, Imm, Waiting}),
            32'({dec_tab[v].ctrl, dec_tab[v].func, dec_tab[v].raddr, dec_tab[v].imm, 1'b0}));
      tick();
      check($sformatf("next_pc_%h", dec_tab[v].instr), 32'(ProgAddr), 32'(dec_tab[v].next_pc));
    end
    SwReady = 1'b0;

    // Per-cycle pipeline trace
    clear_rom();
    rom[0] = 16'h2510;
    rom[1] = 16'h3605;
    rom[2] = 16'h5340;
    restart();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      check($sformatf("pipe_cycle%0d", c + 1),
            32'({ProgAddr, ctrl_now(), Func, Imm}),
            32'({cyc_tab[c].addr, cyc_tab[c].ctrl, cyc_tab[c].func, cyc_tab[c].imm}));
    end

    // Reset asserted mid-EXEC of an LDI at address 1
    clear_rom();
    rom[0] = 16'h2010;
    rom[1] = 16'h2022;
    restart();
    repeat (5) tick();
    check("pre_abort", 32'({WE, ProgAddr, Imm}), 32'({1'b1, 8'h01, 8'h22}));
    #2 nReset = 1'b0;
    #1 check("abort_now", 32'({WE, RegWE, ProgAddr, Imm, Waiting}), 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("abort_held", 32'({WE, RegWE, ProgAddr, Imm, Waiting}), 32'd0);
    @(posedge Clock);
    #1 nReset = 1'b1;
    tick();
    check("post_reset_fetch", 32'({ProgAddr, ctrl_now()}), 32'd0);
    tick();
    tick();
    check("post_reset_exec", 32'({WE, ProgAddr, Imm}), 32'({1'b1, 8'h00, 8'h10}));

    // WTH at address 4, switch low for 20 cycles, then raised
    clear_rom();
    rom[4] = 16'h6000;
    rom[5] = 16'h2077;
    SwReady = 1'b0;
    restart();
    repeat (14) tick();
    for (int k = 0; k < 20; k++) begin
      check($sformatf("wth_stall%0d", k), 32'({Waiting, ProgAddr, ctrl_now()}),
            32'({1'b1, 8'h04, 6'b000000}));
      tick();
    end
    SwReady = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found) begin
        tick();
        if (ProgAddr == 8'h05) found = 1'b1;
      end
    end
    check("wth_release_pc5", 32'(found), 32'd1);
    check("wth_release_waiting", 32'(Waiting), 32'd0);
    tick();
    tick();
    check("wth_next_instr", 32'({WE, ProgAddr, Imm}), 32'({1'b1, 8'h05, 8'h77}));
    SwReady = 1'b0;

    // JMP at 0xFF after NOP at 0xFE
    clear_rom();
    rom[8'h00] = 16'h80FE;
    rom[8'hFF] = 16'h8003;
    restart();
    repeat (3) tick();
    check("jmp_to_fe", 32'(ProgAddr), 32'h00FE);
    repeat (3) tick();
    check("nop_fe_to_ff", 32'(ProgAddr), 32'h00FF);
    repeat (3) tick();
    check("jmp_ff_to_03", 32'(ProgAddr), 32'h0003);

    // NOP at 0xFF wraps the PC
    clear_rom();
    rom[8'h00] = 16'h80FF;
    restart();
    repeat (3) tick();
    check("jmp_to_ff", 32'(ProgAddr), 32'h00FF);
    repeat (3) tick();
    check("pc_wrap", 32'(ProgAddr), 32'h0000);

    // Run dropped during LOAD: instruction completes, FSM parks, then resumes
    clear_rom();
    rom[0] = 16'h2001;
    rom[1] = 16'h2002;
    Run = 1'b1;
    restart();
    tick();
    Run = 1'b0;
    tick();
    check("run0_completes", 32'({WE, ProgAddr, Imm}), 32'({1'b1, 8'h00, 8'h01}));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("run0_parked%0d", k), 32'({ctrl_now(), ProgAddr, Imm}),
            32'({6'b000000, 8'h01, 8'h01}));
    end
    Run = 1'b1;
    tick();
    tick();
    check("run1_resume", 32'({WE, ProgAddr, Imm}), 32'({1'b1, 8'h01, 8'h02}));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
